// File: rtl/levelmap_writer.sv
// Write side of the 320x240 1-bpp collision map.
// Fills the whole map or a single 16x16 tile, one write per cycle.
module levelmap_writer #(
  parameter int MAP_W     = 320,
  parameter int MAP_H     = 240,
  parameter int TILE_SIZE = 16,
  parameter int TILES_X   = MAP_W / TILE_SIZE,
  parameter int TILES_Y   = MAP_H / TILE_SIZE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [4:0]  req_tx,
  input  logic [3:0]  req_ty,
  input  logic        req_value,
  output logic [16:0] map_address,
  output logic        map_data,
  output logic        map_wren,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [16:0] LAST = 17'(MAP_W * MAP_H - 1);
  localparam logic [16:0] ROW  = 17'(MAP_W);
  localparam logic [3:0]  EDGE = 4'(TILE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    TILE_WR,
    FILL_WR,
    FINISH
  } state_t;

  state_t      state;
  logic [16:0] row_base;
  logic [3:0]  px;
  logic [3:0]  py;
  logic [16:0] base;
  logic        tile_ok;
  logic        accept;

  // ty*5120 + tx*16 built from shifts
  assign base = ({13'd0, req_ty} << 12)
              + ({13'd0, req_ty} << 10)
              + ({12'd0, req_tx} << 4);

  assign tile_ok = (req_tx < 5'(TILES_X))
                && (req_ty < 4'(TILES_Y));
  assign req_ready = reset && (state == IDLE);
  assign accept = req_valid && req_ready;
  assign busy = map_wren;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      map_address <= '0;
      map_data    <= 1'b0;
      map_wren    <= 1'b0;
      row_base    <= '0;
      px          <= '0;
      py          <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_op) begin
              state       <= FILL_WR;
              map_address <= '0;
              map_data    <= req_value;
              map_wren    <= 1'b1;
            end else if (tile_ok) begin
              state       <= TILE_WR;
              map_address <= base;
              row_base    <= base;
              px          <= '0;
              py          <= '0;
              map_data    <= req_value;
              map_wren    <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        TILE_WR: begin
          if (px == EDGE) begin
            px <= '0;
            if (py == EDGE) begin
              state    <= FINISH;
              map_wren <= 1'b0;
              done     <= 1'b1;
            end else begin
              py          <= py + 4'd1;
              row_base    <= row_base + ROW;
              map_address <= row_base + ROW;
            end
          end else begin
            px          <= px + 4'd1;
            map_address <= map_address + 17'd1;
          end
        end
        FILL_WR: begin
          if (map_address == LAST) begin
            state    <= FINISH;
            map_wren <= 1'b0;
            done     <= 1'b1;
          end else begin
            map_address <= map_address + 17'd1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_levelmap_writer.sv
// Randomized bench for levelmap_writer.
// Expected write streams come from tile/pixel arithmetic.
module tb_levelmap_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [4:0]  req_tx = '0;
  logic [3:0]  req_ty = '0;
  logic        req_value = 1'b0;
  logic [16:0] map_address;
  logic        map_data;
  logic        map_wren;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  levelmap_writer dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_tx(req_tx),
    .req_ty(req_ty),
    .req_value(req_value),
    .map_address(map_address),
    .map_data(map_data),
    .map_wren(map_wren),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic present(input logic op,
                         input int tx,
                         input int ty,
                         input logic val);
    req_valid = 1'b1;
    req_op    = op;
    req_tx    = 5'(tx);
    req_ty    = 4'(ty);
    req_value = val;
  endtask

  // Called just after the accepting edge; ends on the
  // negedge two cycles after the final write.
  task automatic check_tile(input int tx,
                            input int ty,
                            input logic val);
    int exp;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      exp = (ty * 16 + i / 16) * 320 + tx * 16 + i % 16;
      chk("tile_wren", map_wren, 1);
      chk("tile_addr", map_address, exp);
      chk("tile_data", map_data, val);
      chk("tile_busy", busy, 1);
      chk("tile_done", done, 0);
    end
    @(negedge clock);
    chk("fin_done", done, 1);
    chk("fin_wren", map_wren, 0);
    chk("fin_busy", busy, 0);
    chk("fin_ready", req_ready, 0);
    chk("fin_err", err, 0);
    @(negedge clock);
    chk("post_ready", req_ready, 1);
    chk("post_done", done, 0);
  endtask

  task automatic run_tile(input int tx,
                          input int ty,
                          input logic val);
    chk("pre_ready", req_ready, 1);
    present(1'b0, tx, ty, val);
    @(posedge clock);
    #1 req_valid = 1'b0;
    check_tile(tx, ty, val);
  endtask

  task automatic run_bad(input int tx, input int ty);
    present(1'b0, tx, ty, 1'b1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("bad_err", err, 1);
    chk("bad_wren", map_wren, 0);
    chk("bad_done", done, 0);
    chk("bad_ready", req_ready, 1);
    @(negedge clock);
    chk("bad_err_clr", err, 0);
    chk("bad_wren2", map_wren, 0);
  endtask

  initial begin
    int tx;
    int ty;
    logic v;
    int ok;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_wren", map_wren, 0);
    chk("rst_addr", map_address, 0);
    chk("rst_data", map_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 0);
    reset = 1'b1;
    #1 chk("rel_ready", req_ready, 1);
    @(negedge clock);

    run_tile(0, 0, 1'b0);
    run_tile(19, 14, 1'b1);

    for (int k = 0; k < 4; k++) begin
      tx = $urandom_range(0, 19);
      ty = $urandom_range(0, 14);
      v  = 1'($urandom_range(0, 1));
      run_tile(tx, ty, v);
    end

    // reject then immediately accept a valid request
    present(1'b0, 20, 3, 1'b1);
    @(posedge clock);
    #1 present(1'b0, 5, 6, 1'b1);
    @(negedge clock);
    chk("rej_err", err, 1);
    chk("rej_wren", map_wren, 0);
    chk("rej_done", done, 0);
    chk("rej_ready", req_ready, 1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    check_tile(5, 6, 1'b1);

    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        tx = $urandom_range(0, 19);
        ty = 15;
      end else begin
        tx = $urandom_range(20, 31);
        ty = $urandom_range(0, 15);
      end
      run_bad(tx, ty);
    end

    // reset on write #100
    present(1'b0, 7, 3, 1'b1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (100) @(negedge clock);
    chk("mid_addr99", map_address,
        (3 * 16 + 6) * 320 + 7 * 16 + 3);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("abort_wren", map_wren, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      chk("abort_ready", req_ready, 0);
    end
    reset = 1'b1;
    #1 chk("abort_rel", req_ready, 1);
    @(negedge clock);
    present(1'b0, 2, 1, 1'b0);
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("restart_base", map_address, 5152);
    chk("restart_wren", map_wren, 1);
    repeat (260) @(negedge clock);

    // held valid; fields change after the first handshake
    present(1'b0, 3, 4, 1'b1);
    @(posedge clock);
    #1 present(1'b0, 11, 9, 1'b0);
    check_tile(3, 4, 1'b1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    check_tile(11, 9, 1'b0);

    // full map fill
    present(1'b1, 31, 15, 1'b1);
    @(posedge clock);
    #1 begin
      req_valid = 1'b0;
      req_value = 1'b0;
    end
    ok = 1;
    for (int i = 0; i < 76800; i++) begin
      @(negedge clock);
      if (ok != 0 && (map_wren !== 1'b1 ||
          map_address !== 17'(i) ||
          map_data !== 1'b1 || busy !== 1'b1 ||
          done !== 1'b0)) begin
        chk("fill_wren", map_wren, 1);
        chk("fill_addr", map_address, i);
        chk("fill_data", map_data, 1);
        chk("fill_busy", busy, 1);
        ok = 0;
      end
    end
    chk("fill_stream", ok, 1);
    @(negedge clock);
    chk("fill_done", done, 1);
    chk("fill_wren_end", map_wren, 0);
    chk("fill_busy_end", busy, 0);
    @(negedge clock);
    chk("fill_ready", req_ready, 1);
    chk("fill_done_clr", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/levelmap_writer.md
Name: levelmap_writer

Overview:
- Write-side companion to the collision lookup path. It fills the 1-bit-per-pixel level collision map RAM (320x240, 17-bit linear address = y*320 + x).
- Serves two request types: whole-map fill, and 16x16 tile write at tile coordinates. Used on level load and when map features change, e.g. a bush is cut or a door opens.
- Control holds collision checks off while busy is high.
- Map bit convention: 1 = walkable, 0 = blocked.

Parameters:
- MAP_W, 320, map width in pixels (row stride).
- MAP_H, 240, map height in pixels.
- TILE_SIZE, 16, tile edge in pixels. Must be a power of 2.
- TILES_X, 20, MAP_W/TILE_SIZE.
- TILES_Y, 15, MAP_H/TILE_SIZE.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  1  0 = TILE write, 1 = FILL whole map.
- req_tx  in  5  tile column, valid range 0..19 (ignored for FILL).
- req_ty  in  4  tile row, valid range 0..14 (ignored for FILL).
- req_value  in  1  bit written to every addressed pixel.
- map_address  out  17  RAM write address.
- map_data  out  1  RAM write data.
- map_wren  out  1  RAM write enable.
- busy  out  1  high while writes are in progress.
- done  out  1  one-cycle pulse after the final write of a request.
- err  out  1  one-cycle pulse when a TILE request is rejected.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - map_wren=0, map_address=0, map_data=0, busy=0, done=0, err=0.
  - req_ready=0 while reset is asserted; req_ready=1 on the first cycle after release.
- Handshake:
  - A request is accepted on a clock edge where req_valid && req_ready.
  - req_op, req_tx, req_ty and req_value are latched at acceptance; later input changes have no effect.
  - req_ready=1 only in IDLE.
- FSM states: IDLE, TILE_WR, FILL_WR, FINISH.
- IDLE transitions on an accepted request:
  - FILL -> FILL_WR.
  - TILE with tx<=19 and ty<=14 -> TILE_WR.
  - TILE with tx>19 or ty>14 -> stay in IDLE. err=1 for the next cycle, no writes, no done, req_ready stays 1.
- TILE_WR:
  - Tile base = ty*5120 + tx*16, formed as (ty<<12)+(ty<<10)+(tx<<4). No multiplier.
  - Counters px (inner) and py (outer), each 0..15.
  - Address = base + py*320 + px. The row base is incremented by 320 when px wraps 15->0; no multiplier.
  - One write per cycle, 256 writes in row-major order, px fastest.
- FILL_WR:
  - 76800 writes, one per cycle, addresses 0..76799 ascending.
- Write outputs:
  - map_address, map_data and map_wren are registered.
  - The first write appears on the cycle after acceptance.
  - map_data = latched req_value on every write cycle.
- busy=1 exactly on the cycles where map_wren=1.
- FINISH: entered after the last write.
  - Outputs: done=1, map_wren=0, busy=0, req_ready=0.
  - Returns to IDLE on the next cycle.
- Timeline for a TILE request accepted at cycle 0:
  - Writes on cycles 1..256.
  - done on cycle 257.
  - req_ready on cycle 258.
- Timeline for a FILL request accepted at cycle 0:
  - Writes on cycles 1..76800.
  - done on cycle 76801.
- Address arithmetic: 17-bit unsigned. The maximum generated address is 76799, so no wrap-around is possible. The largest tile (19,14) ends exactly at 76799.
- Held req_valid: back-to-back requests are accepted only in IDLE. There is no queue; the upstream holds req_valid until it sees req_ready.
- Reset mid-operation:
  - The operation aborts at that edge; map_wren is 0 from that edge on.
  - No done and no err for the aborted request. Partial writes are not undone.
- done and err are never asserted in the same cycle.

Test Plan:
- Reset release, then TILE tx=0 ty=0 value=0:
  - Writes 0..15, 320..335, ..., 4800..4815 on cycles 1..256.
  - done=1 on cycle 257, req_ready=1 on cycle 258.
- TILE tx=19 ty=14 value=1:
  - First address 71984, 16th address 71999, 17th address 72304, last address 76799.
  - Exactly 256 wren cycles, all with data=1.
- TILE tx=20 ty=3:
  - err=1 for one cycle, map_wren stays 0, done stays 0.
  - A following valid request is accepted on the next cycle.
- FILL value=1:
  - Addresses 0..76799 ascending, contiguous, no gaps.
  - busy high for 76800 cycles, done on cycle 76801.
- reset=0 during write #100 of a TILE request:
  - map_wren=0 from that edge on, no done.
  - After release, req_ready=1 and a new TILE (2,1) starts at base 5152.
- req_valid held high with two queued TILE requests (driver changes fields after the first handshake):
  - Second request accepted at cycle 258.
  - First request's writes use the first request's latched fields throughout.
